// File: rtl/nibble_mul_seq_pkg.sv
// Shared types for the sequential nibble multiplier: FSM encoding, nibble width,
// default sizing and the 2x2 vedic cell used inside vedic_4bit.
package nibble_mul_seq_pkg;

  localparam int NIB           = 4;
  localparam int W_DEF         = 8;
  localparam int ACC_GUARD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [NIB-1:0] a;
    logic [NIB-1:0] b;
  } nib_pair_t;

  // Urdhva-tiryagbhyam 2x2 cell: vertical and crosswise products with half adders.
  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, c, h;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    c  = t1 & t2;
    h  = x[1] & y[1];
    return {h & c, h ^ c, t1 ^ t2, x[0] & y[0]};
  endfunction

endpackage

// File: rtl/vedic_4bit.sv
// Combinational 4x4 unsigned vedic multiplier built from four 2x2 cells.
module vedic_4bit
  import nibble_mul_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] q0, q1, q2, q3;
  logic [5:0] mid;

  assign q0 = vedic2(a[1:0], b[1:0]);
  assign q1 = vedic2(a[3:2], b[1:0]);
  assign q2 = vedic2(a[1:0], b[3:2]);
  assign q3 = vedic2(a[3:2], b[3:2]);

  // Cross terms plus the carry-out half of q0; max 9+9+3 fits in 6 bits.
  assign mid = {2'b00, q1} + {2'b00, q2} + {4'b0000, q0[3:2]};
  assign p   = {({q3, 2'b00} + mid), q0[1:0]};

endmodule

// File: rtl/nibble_mul_seq.sv
// Sequential WxW unsigned multiplier: one nibble pair per cycle through a single
// vedic_4bit. Optional running-sum mode via `define NIBBLE_MUL_ACCUMULATE_EN.
module nibble_mul_seq
  import nibble_mul_seq_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int ACC_GUARD = ACC_GUARD_DEF,
`ifdef NIBBLE_MUL_ACCUMULATE_EN
  localparam int PW       = 2*W + ACC_GUARD
`else
  localparam int PW       = 2*W
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product,
`ifdef NIBBLE_MUL_ACCUMULATE_EN
  input  logic          acc_clr,
`endif
  output logic          busy
);

  localparam int N  = W / NIB;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  generate
    if ((W % NIB) != 0 || W < NIB || ACC_GUARD < 0) begin : g_bad_cfg
      initial begin
        $display("nibble_mul_seq: W=%0d must be a multiple of 4 and >= 4", W);
        $finish;
      end
    end
  endgenerate

  state_t        state;
  logic [W-1:0]  a_reg, b_reg;
  logic [IW-1:0] i, j;
  logic [PW-1:0] acc;

  logic [N-1:0][NIB-1:0] a_n, b_n;
  nib_pair_t             np;
  logic [7:0]            pp;
  logic [IW:0]           ij;
  logic [PW-1:0]         pp_sh, acc_next;

  assign a_n  = a_reg;
  assign b_n  = b_reg;
  assign np.a = a_n[i];
  assign np.b = b_n[j];

  vedic_4bit u_vedic (
    .a (np.a),
    .b (np.b),
    .p (pp)
  );

  // Partial product weight is 16^(i+j); the sum cannot exceed 2W bits.
  assign ij       = {1'b0, i} + {1'b0, j};
  assign pp_sh    = PW'(pp) << (NIB * int'(ij));
  assign acc_next = acc + pp_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      i         <= '0;
      j         <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            i        <= '0;
            j        <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifndef NIBBLE_MUL_ACCUMULATE_EN
            acc      <= '0;
`endif
          end
`ifdef NIBBLE_MUL_ACCUMULATE_EN
          // Clear applies with or without a new accept, so clr+valid yields the new product alone.
          if (acc_clr) acc <= '0;
`endif
        end
        CALC: begin
          acc <= acc_next;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i         <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
              product   <= acc_next;
            end else begin
              i <= i + 1'b1;
            end
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_mul_seq.sv
// Self-checking bench for nibble_mul_seq (W=8): vector table, handshake corner
// sequences, and random operands against an arithmetic reference.
module tb_nibble_mul_seq;

  localparam int W = 8;
`ifdef NIBBLE_MUL_ACCUMULATE_EN
  localparam int PW = 2*W + 8;
`else
  localparam int PW = 2*W;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] product;
  logic          busy;
`ifdef NIBBLE_MUL_ACCUMULATE_EN
  logic          acc_clr = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  nibble_mul_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
`ifdef NIBBLE_MUL_ACCUMULATE_EN
    .acc_clr   (acc_clr),
`endif
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_clr(input logic v);
`ifdef NIBBLE_MUL_ACCUMULATE_EN
    acc_clr = v;
`else
    if (v) ;
`endif
  endtask

  task automatic wait_ov(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One full transaction with optional backpressure before the handshake.
  task automatic do_mul(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic clr, input int hold, input logic [PW-1:0] exp);
    int lat;
    bit stable;
    @(negedge clk);
    chk({nm, "_rdy"}, in_ready, 1'b1);
    a = ta; b = tb; in_valid = 1'b1; set_clr(clr);
    @(posedge clk); #1;
    in_valid = 1'b0; set_clr(1'b0);
    a = $urandom; b = $urandom;
    wait_ov(lat);
    chk({nm, "_lat"}, lat, 4);
    chk({nm, "_prod"}, product, exp);
    stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (product !== exp || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) chk({nm, "_hold"}, stable, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_hs"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            hold;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t tbl[7];
  logic [PW-1:0] model;

  initial begin
    int lat;
    bit quiet;
    tbl[0] = '{8'hFF, 8'hFF, 0, 16'hFE01};
    tbl[1] = '{8'h0D, 8'h0B, 0, 16'h008F};
    tbl[2] = '{8'h00, 8'hA5, 0, 16'h0000};
    tbl[3] = '{8'h12, 8'h34, 5, 16'h03A8};
    tbl[4] = '{8'hF0, 8'h0F, 1, 16'h0E10};
    tbl[5] = '{8'h80, 8'h02, 0, 16'h0100};
    tbl[6] = '{8'h01, 8'h01, 2, 16'h0001};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {in_ready, out_valid, busy}, 3'b100);
    chk("rst_prod", product, '0);
    @(negedge clk) rst_n = 1'b1;

`ifdef NIBBLE_MUL_ACCUMULATE_EN
    do_mul("acc_pre", 8'h07, 8'h07, 1'b0, 0, 24'h31);
    @(negedge clk) acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
    do_mul("acc_3x5", 8'h03, 8'h05, 1'b0, 0, 24'h0F);
    do_mul("acc_4x4", 8'h04, 8'h04, 1'b0, 0, 24'h1F);
    do_mul("acc_clr2x2", 8'h02, 8'h02, 1'b1, 0, 24'h04);
    model = 24'h04;
`else
    for (int k = 0; k < 7; k++)
      do_mul($sformatf("tbl%0d", k), tbl[k].a, tbl[k].b, 1'b0, tbl[k].hold, PW'(tbl[k].exp));
    model = '0;
`endif

    // Operands change and in_valid stays high during CALC; out_ready high early.
    @(negedge clk);
    a = 8'h21; b = 8'h03; in_valid = 1'b1; out_ready = 1'b1; set_clr(1'b1);
    @(posedge clk); #1;
    a = 8'hFF; b = 8'hFF; set_clr(1'b0);
    chk("mid_inrdy", in_ready, 1'b0);
    wait_ov(lat);
    chk("mid_lat", lat, 4);
    chk("mid_prod", product, PW'(16'h0063));
    @(posedge clk); #1;
    chk("mid_hs", {out_valid, in_ready, busy}, 3'b010);
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_acc2", {in_ready, busy}, 2'b01);
    wait_ov(lat);
    chk("mid2_lat", lat, 4);
`ifdef NIBBLE_MUL_ACCUMULATE_EN
    chk("mid2_prod", product, 24'hFE64);
`else
    chk("mid2_prod", product, 16'hFE01);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("mid2_hs", {out_valid, in_ready}, 2'b01);

    // Reset during the second CALC cycle.
    @(negedge clk);
    a = 8'h12; b = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_state", {in_ready, out_valid, busy}, 3'b100);
    chk("rstmid_prod", product, '0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    chk("rstmid_quiet", quiet, 1'b1);
    model = '0;

    // Random operands against the arithmetic reference.
    for (int k = 0; k < 30; k++) begin
      logic [W-1:0] ra, rb;
      logic clr;
      ra  = W'($urandom);
      rb  = W'($urandom);
      clr = ($urandom_range(0, 3) == 0);
`ifdef NIBBLE_MUL_ACCUMULATE_EN
      if (clr) model = '0;
      model = model + PW'(ra) * PW'(rb);
`else
      model = PW'(ra) * PW'(rb);
`endif
      do_mul($sformatf("rnd%0d", k), ra, rb, clr, $urandom_range(0, 2), model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
